// File: rtl/vq_pkg.sv
// Shared constants and types for the speaker VQ codebook bank.
// The enrollment writer, its interface and the bench all import this package.
package vq_pkg;

  localparam int CW_NUM   = 16;
  localparam int COEF_NUM = 13;
  localparam int DATA_W   = 14;
  localparam int ADDR_W   = 8;
  localparam int N_WORDS  = CW_NUM * COEF_NUM;
  localparam int SLOT_NUM = 4;
  localparam int SLOT_W   = 2;
  localparam int CSUM_W   = DATA_W + 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COPY,
    ST_FLUSH,
    ST_DONE
  } enroll_state_t;

endpackage

// File: rtl/vq_codebook_enroll_if.sv
// Command, training-buffer read and codebook-RAM write signals of the enrollment writer.
// slave is the writer's view; master is the view of the block driving it.
interface vq_codebook_enroll_if;
  import vq_pkg::*;

  logic                        enroll_start;
  logic                        enroll_clear;
  logic [SLOT_W-1:0]           speaker_id;
  logic                        vq_busy;
  logic                        src_rd;
  logic [ADDR_W-1:0]           src_addr;
  logic signed [DATA_W-1:0]    src_data;
  logic                        dst_we;
  logic [ADDR_W+SLOT_W-1:0]    dst_addr;
  logic signed [DATA_W-1:0]    dst_data;
  logic [SLOT_NUM-1:0]         spk_valid;
  logic                        busy;
  logic                        enroll_done;
  logic [CSUM_W-1:0]           checksum;

  modport slave (
    input  enroll_start, enroll_clear, speaker_id, vq_busy, src_data,
    output src_rd, src_addr, dst_we, dst_addr, dst_data,
           spk_valid, busy, enroll_done, checksum
  );

  modport master (
    output enroll_start, enroll_clear, speaker_id, vq_busy, src_data,
    input  src_rd, src_addr, dst_we, dst_addr, dst_data,
           spk_valid, busy, enroll_done, checksum
  );

endinterface

// File: rtl/vq_codebook_enroll.sv
// Copies one trained LBG codebook from the training buffer into a speaker slot
// of the codebook RAM, keeping per-slot valid flags and a checksum of the copy.
module vq_codebook_enroll
  import vq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  vq_codebook_enroll_if.slave  bus
);

  enroll_state_t             state_q;
  logic [SLOT_W-1:0]         slot_q;
  logic                      src_rd_q;
  logic [ADDR_W-1:0]         src_addr_q;
  logic                      vld_p0;
  logic [ADDR_W-1:0]         off_p0;
  logic [SLOT_NUM-1:0]       spk_valid_q;
  logic                      done_q;
  logic [CSUM_W-1:0]         csum_q;

  // Coefficients are signed, but the checksum treats each word as its raw bits.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0]     acc,
                                                 input logic signed [DATA_W-1:0] word);
    logic [CSUM_W-1:0] word_zx;
    word_zx = {{(CSUM_W-DATA_W){1'b0}}, word};
    return acc + word_zx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      src_rd_q    <= 1'b0;
      src_addr_q  <= '0;
      vld_p0      <= 1'b0;
      off_p0      <= '0;
      spk_valid_q <= '0;
      done_q      <= 1'b0;
      csum_q      <= '0;
    end else begin
      done_q <= 1'b0;
      // p0: read data returns one cycle after the strobe; write it with the offset it was read from
      vld_p0 <= src_rd_q;
      off_p0 <= src_addr_q;
      if (vld_p0) begin
        csum_q <= csum_add(csum_q, bus.src_data);
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.enroll_start) begin
            slot_q                      <= bus.speaker_id;
            spk_valid_q[bus.speaker_id] <= 1'b0;
            csum_q                      <= '0;
            if (bus.vq_busy) begin
              state_q <= ST_WAIT;
            end else begin
              state_q    <= ST_COPY;
              src_rd_q   <= 1'b1;
              src_addr_q <= '0;
            end
          end else if (bus.enroll_clear) begin
            spk_valid_q[bus.speaker_id] <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (!bus.vq_busy) begin
            state_q    <= ST_COPY;
            src_rd_q   <= 1'b1;
            src_addr_q <= '0;
          end
        end

        ST_COPY: begin
          // Once started the copy runs to the end; the identifier gates on busy.
          if (src_addr_q == ADDR_W'(N_WORDS - 1)) begin
            state_q    <= ST_FLUSH;
            src_rd_q   <= 1'b0;
            src_addr_q <= '0;
          end else begin
            src_addr_q <= src_addr_q + 1'b1;
          end
        end

        ST_FLUSH: begin
          state_q             <= ST_DONE;
          spk_valid_q[slot_q] <= 1'b1;
          done_q              <= 1'b1;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.src_rd      = src_rd_q;
  assign bus.src_addr    = src_addr_q;
  assign bus.dst_we      = vld_p0;
  assign bus.dst_addr    = vld_p0 ? {slot_q, off_p0} : '0;
  assign bus.dst_data    = vld_p0 ? bus.src_data : '0;
  assign bus.spk_valid   = spk_valid_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.enroll_done = done_q;
  assign bus.checksum    = csum_q;

endmodule

// File: tb/tb_vq_codebook_enroll.sv
// Bench for vq_codebook_enroll: random and ramp codebooks copied into slots,
// checked against a reference of the expected RAM writes, timing and checksum.
module tb_vq_codebook_enroll;
  import vq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vq_codebook_enroll_if bus();

  vq_codebook_enroll dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [SLOT_NUM-1:0] exp_valid;

  logic [DATA_W-1:0] src_mem [0:255];

  // Training buffer: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.src_rd) bus.src_data <= src_mem[bus.src_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W+1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int                wr_cyc_q  [$];
  logic [ADDR_W-1:0] rd_addr_q [$];
  int                rd_cyc_q  [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dst_we) begin
        wr_addr_q.push_back(bus.dst_addr);
        wr_data_q.push_back(bus.dst_data);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.src_rd) begin
        rd_addr_q.push_back(bus.src_addr);
        rd_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < 256; n++) src_mem[n] = DATA_W'(n + 100);
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 256; n++) src_mem[n] = DATA_W'($urandom);
  endtask

  // Reference: every buffer word, read as unsigned, summed.
  function automatic logic [CSUM_W-1:0] model_csum();
    logic [CSUM_W-1:0] s;
    s = '0;
    for (int n = 0; n < N_WORDS; n++) s = s + CSUM_W'(src_mem[n]);
    return s;
  endfunction

  // Reference: word n lands at {slot, n} with buffer word n, at cycle t_wr0+n.
  function automatic int write_errs(input int slot, input int t_wr0);
    int e;
    logic [ADDR_W+1:0] ea;
    e = 0;
    if (wr_addr_q.size() != N_WORDS) e++;
    for (int n = 0; n < wr_addr_q.size() && n < N_WORDS; n++) begin
      ea = (ADDR_W+2)'(slot * (1 << ADDR_W) + n);
      if (wr_addr_q[n] !== ea) e++;
      if (wr_data_q[n] !== src_mem[n]) e++;
      if (wr_cyc_q[n] != t_wr0 + n) e++;
    end
    return e;
  endfunction

  function automatic int read_errs(input int t_rd0);
    int e;
    e = 0;
    if (rd_addr_q.size() != N_WORDS) e++;
    for (int n = 0; n < rd_addr_q.size() && n < N_WORDS; n++) begin
      if (rd_addr_q[n] !== ADDR_W'(n)) e++;
      if (rd_cyc_q[n] != t_rd0 + n) e++;
    end
    return e;
  endfunction

  task automatic pulse_start(input logic [1:0] id, output int t0);
    t0 = cyc;
    bus.speaker_id   = id;
    bus.enroll_start = 1'b1;
    tick();
    bus.enroll_start = 1'b0;
  endtask

  // Returns the cycle stamp of enroll_done, or -1 if it never came.
  task automatic wait_done(input int budget, output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.enroll_done === 1'b1) begin
        dcyc = cyc;
        seen = 1'b1;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_valid = '0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.src_rd, bus.dst_we, bus.busy, bus.enroll_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.src_rd, bus.dst_we, bus.busy, bus.enroll_done});
    end
    checks++;
    if ({bus.src_addr, bus.dst_addr, bus.dst_data} !== '0) begin
      failures++;
      $display("FAIL reset_bus: src_addr=%0h dst_addr=%0h dst_data=%0h expected 0", bus.src_addr, bus.dst_addr, bus.dst_data);
    end
    checks++;
    if (bus.spk_valid !== 4'b0000 || bus.checksum !== '0) begin
      failures++;
      $display("FAIL reset_state: spk_valid=%b checksum=%0d expected 0", bus.spk_valid, bus.checksum);
    end
    rst_n = 1'b1;
    exp_valid = '0;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.src_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b src_rd=%b expected 0", bus.busy, bus.src_rd);
    end
  endtask

  task automatic test_basic_enroll();
    int t0, d, we, re;
    fill_ramp();
    clear_logs();
    pulse_start(2'd2, t0);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    wait_done(400, d);
    exp_valid[2] = 1'b1;
    checks++;
    if (d - t0 !== N_WORDS + 2) begin
      failures++;
      $display("FAIL basic_done_cycle: got %0d expected %0d", d - t0, N_WORDS + 2);
    end
    we = write_errs(2, t0 + 2);
    checks++;
    if (we !== 0) begin
      failures++;
      $display("FAIL basic_writes: %0d bad fields over %0d writes, expected 0 bad and %0d writes", we, wr_addr_q.size(), N_WORDS);
    end
    re = read_errs(t0 + 1);
    checks++;
    if (re !== 0) begin
      failures++;
      $display("FAIL basic_reads: %0d bad fields over %0d reads", re, rd_addr_q.size());
    end
    checks++;
    if (bus.spk_valid !== exp_valid) begin
      failures++;
      $display("FAIL basic_valid: got %b expected %b", bus.spk_valid, exp_valid);
    end
    checks++;
    if (bus.checksum !== model_csum()) begin
      failures++;
      $display("FAIL basic_checksum: got %0d expected %0d", bus.checksum, model_csum());
    end
  endtask

  task automatic test_random_enroll();
    int t0, d, we;
    logic [1:0] slot;
    for (int it = 0; it < 2; it++) begin
      fill_rand();
      clear_logs();
      slot = 2'($urandom_range(0, 3));
      pulse_start(slot, t0);
      wait_done(400, d);
      exp_valid[slot] = 1'b1;
      we = write_errs(slot, t0 + 2);
      checks++;
      if (we !== 0 || d - t0 !== N_WORDS + 2) begin
        failures++;
        $display("FAIL rand_copy slot %0d: bad fields %0d latency %0d expected 0 and %0d", slot, we, d - t0, N_WORDS + 2);
      end
      checks++;
      if (bus.checksum !== model_csum() || bus.spk_valid !== exp_valid) begin
        failures++;
        $display("FAIL rand_result: checksum %0d valid %b expected %0d %b", bus.checksum, bus.spk_valid, model_csum(), exp_valid);
      end
    end
  endtask

  task automatic test_vq_busy_wait();
    int t0, tf, d, early;
    fill_rand();
    clear_logs();
    bus.vq_busy = 1'b1;
    pulse_start(2'd1, t0);
    repeat (49) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.spk_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: busy=%b valid1=%b expected 1 0", bus.busy, bus.spk_valid[1]);
    end
    tf = cyc;
    bus.vq_busy = 1'b0;
    wait_done(400, d);
    exp_valid[1] = 1'b1;
    early = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] <= tf) early++;
    foreach (wr_cyc_q[i]) if (wr_cyc_q[i] <= tf) early++;
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL wait_no_access: got %0d accesses while vq_busy high expected 0", early);
    end
    checks++;
    if (read_errs(tf + 1) !== 0 || write_errs(1, tf + 2) !== 0) begin
      failures++;
      $display("FAIL wait_copy: read errs %0d write errs %0d expected 0", read_errs(tf + 1), write_errs(1, tf + 2));
    end
    checks++;
    if (d - tf !== N_WORDS + 2) begin
      failures++;
      $display("FAIL wait_done_cycle: got %0d expected %0d", d - tf, N_WORDS + 2);
    end
  endtask

  task automatic test_reenroll();
    int t0, d, bad, done_at;
    do_reset();
    fill_rand();
    pulse_start(2'd0, t0);
    wait_done(400, d);
    exp_valid[0] = 1'b1;
    checks++;
    if (bus.spk_valid !== 4'b0001) begin
      failures++;
      $display("FAIL reenroll_pre: got %b expected 0001", bus.spk_valid);
    end
    fill_rand();
    clear_logs();
    bad = 0;
    done_at = -1;
    pulse_start(2'd0, t0);
    while (cyc - t0 < N_WORDS + 5) begin
      @(negedge clk);
      if (bus.spk_valid[0] !== ((cyc - t0) >= N_WORDS + 2)) bad++;
      if (bus.enroll_done === 1'b1) done_at = cyc - t0;
    end
    tick();
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reenroll_valid_window: %0d cycles with wrong spk_valid[0]", bad);
    end
    checks++;
    if (done_at !== N_WORDS + 2 || write_errs(0, t0 + 2) !== 0) begin
      failures++;
      $display("FAIL reenroll_copy: done at %0d expected %0d write errs %0d", done_at, N_WORDS + 2, write_errs(0, t0 + 2));
    end
  endtask

  task automatic test_ignore_while_busy();
    int t0, d;
    fill_rand();
    clear_logs();
    pulse_start(2'd3, t0);
    repeat (20) tick();
    bus.speaker_id = 2'd1;
    bus.enroll_start = 1'b1;
    tick();
    bus.enroll_start = 1'b0;
    repeat (30) tick();
    bus.speaker_id = 2'd0;
    bus.enroll_clear = 1'b1;
    tick();
    bus.enroll_clear = 1'b0;
    wait_done(400, d);
    exp_valid[3] = 1'b1;
    repeat (20) tick();
    checks++;
    if (write_errs(3, t0 + 2) !== 0 || d - t0 !== N_WORDS + 2) begin
      failures++;
      $display("FAIL ignore_copy: write errs %0d over %0d writes latency %0d expected 0 and %0d", write_errs(3, t0 + 2), wr_addr_q.size(), d - t0, N_WORDS + 2);
    end
    checks++;
    if (bus.spk_valid !== exp_valid || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_state: valid %b busy %b expected %b 0", bus.spk_valid, bus.busy, exp_valid);
    end
  endtask

  task automatic test_reset_mid_copy();
    int t0, d;
    fill_rand();
    clear_logs();
    pulse_start(2'd1, t0);
    while (cyc < t0 + 100) tick();
    checks++;
    if (bus.src_rd !== 1'b1 || bus.dst_we !== 1'b1) begin
      failures++;
      $display("FAIL midcopy_active: src_rd=%b dst_we=%b expected 1 1", bus.src_rd, bus.dst_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.src_rd, bus.dst_we, bus.busy, bus.enroll_done, bus.spk_valid} !== '0 ||
        {bus.src_addr, bus.dst_addr, bus.dst_data, bus.checksum} !== '0) begin
      failures++;
      $display("FAIL midcopy_reset: rd %b we %b busy %b valid %b sa %0h da %0h dd %0h cs %0d expected all 0",
               bus.src_rd, bus.dst_we, bus.busy, bus.spk_valid, bus.src_addr, bus.dst_addr, bus.dst_data, bus.checksum);
    end
    tick();
    rst_n = 1'b1;
    exp_valid = '0;
    tick();
    fill_rand();
    clear_logs();
    pulse_start(2'd2, t0);
    wait_done(400, d);
    exp_valid[2] = 1'b1;
    checks++;
    if (write_errs(2, t0 + 2) !== 0 || bus.checksum !== model_csum() || bus.spk_valid !== exp_valid) begin
      failures++;
      $display("FAIL post_reset_enroll: write errs %0d checksum %0d valid %b expected 0 %0d %b",
               write_errs(2, t0 + 2), bus.checksum, bus.spk_valid, model_csum(), exp_valid);
    end
  endtask

  task automatic test_clear();
    int t0, d;
    for (int s = 0; s < SLOT_NUM; s++) begin
      if (!exp_valid[s]) begin
        fill_rand();
        pulse_start(2'(s), t0);
        wait_done(400, d);
        exp_valid[s] = 1'b1;
      end
    end
    checks++;
    if (bus.spk_valid !== 4'b1111) begin
      failures++;
      $display("FAIL clear_pre: got %b expected 1111", bus.spk_valid);
    end
    clear_logs();
    bus.speaker_id = 2'd3;
    bus.enroll_clear = 1'b1;
    tick();
    bus.enroll_clear = 1'b0;
    exp_valid[3] = 1'b0;
    checks++;
    if (bus.spk_valid !== exp_valid) begin
      failures++;
      $display("FAIL clear_valid: got %b expected %b", bus.spk_valid, exp_valid);
    end
    repeat (5) tick();
    checks++;
    if (wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_copy: writes %0d reads %0d busy %b expected 0 0 0", wr_addr_q.size(), rd_addr_q.size(), bus.busy);
    end
  endtask

  task automatic test_start_clear_same();
    int t0, d;
    fill_rand();
    clear_logs();
    t0 = cyc;
    bus.speaker_id = 2'd3;
    bus.enroll_start = 1'b1;
    bus.enroll_clear = 1'b1;
    tick();
    bus.enroll_start = 1'b0;
    bus.enroll_clear = 1'b0;
    wait_done(400, d);
    exp_valid[3] = 1'b1;
    checks++;
    if (write_errs(3, t0 + 2) !== 0 || bus.spk_valid !== exp_valid || bus.checksum !== model_csum()) begin
      failures++;
      $display("FAIL start_beats_clear: write errs %0d valid %b checksum %0d expected 0 %b %0d",
               write_errs(3, t0 + 2), bus.spk_valid, bus.checksum, exp_valid, model_csum());
    end
  endtask

  initial begin
    bus.enroll_start = 1'b0;
    bus.enroll_clear = 1'b0;
    bus.speaker_id   = '0;
    bus.vq_busy      = 1'b0;
    rst_n            = 1'b0;
    exp_valid        = '0;
    test_reset();
    test_basic_enroll();
    test_random_enroll();
    test_vq_busy_wait();
    test_reenroll();
    test_ignore_while_busy();
    test_reset_mid_copy();
    test_clear();
    test_start_clear_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
